// File: rtl/apb_bridge_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bridge_pkg : shared state encoding and widths for apb_bridge_fsm    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bridge_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int SEL_W      = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WWAIT    = 3'd1,
      ST_READ     = 3'd2,
      ST_WRITE    = 3'd3,
      ST_WRITEP   = 3'd4,
      ST_RENABLE  = 3'd5,
      ST_WENABLE  = 3'd6,
      ST_WENABLEP = 3'd7
   } state_t;

   // SETUP phases are the only cycles in which the AHB side is stalled.
   function automatic logic is_setup(input state_t s);
      return (s == ST_READ) || (s == ST_WRITE) || (s == ST_WRITEP);
   endfunction

   function automatic logic is_enable(input state_t s);
      return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_bridge_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_bridge_fsm_if : AHB-side inputs and APB-side outputs of bridge  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface apb_bridge_fsm_if #(
   parameter int ADDR_W = bridge_pkg::DEF_ADDR_W,
   parameter int DATA_W = bridge_pkg::DEF_DATA_W,
   parameter int SEL_W  = bridge_pkg::SEL_W
);
   logic              valid;
   logic              hwrite;
   logic              hwrite_reg;
   logic [ADDR_W-1:0] haddr;
   logic [ADDR_W-1:0] haddr_1;
   logic [ADDR_W-1:0] haddr_2;
   logic [DATA_W-1:0] hwdata;
   logic [SEL_W-1:0]  tempselx;
   logic [DATA_W-1:0] prdata;

   logic              pwrite;
   logic              penable;
   logic [SEL_W-1:0]  pselx;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              hreadyout;
   logic [DATA_W-1:0] hrdata;

   modport master (
      input  valid, hwrite, hwrite_reg, haddr, haddr_1, haddr_2, hwdata, tempselx, prdata,
      output pwrite, penable, pselx, paddr, pwdata, hreadyout, hrdata
   );

   modport slave (
      output valid, hwrite, hwrite_reg, haddr, haddr_1, haddr_2, hwdata, tempselx, prdata,
      input  pwrite, penable, pselx, paddr, pwdata, hreadyout, hrdata
   );
endinterface
`default_nettype wire

// File: rtl/apb_bridge_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_bridge_fsm : APB master controller of the AHB-to-APB bridge     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_bridge_fsm #(
   parameter int ADDR_W = bridge_pkg::DEF_ADDR_W,
   parameter int DATA_W = bridge_pkg::DEF_DATA_W,
   parameter int SEL_W  = bridge_pkg::SEL_W
) (
   input wire logic         hclk,
   input wire logic         hresetn,
   apb_bridge_fsm_if.master bus
);
   import bridge_pkg::*;

   state_t            r_state;
   state_t            w_next_state;

   logic              r_pwrite,    w_pwrite;
   logic              r_penable,   w_penable;
   logic [SEL_W-1:0]  r_pselx,     w_pselx;
   logic [ADDR_W-1:0] r_paddr,     w_paddr;
   logic [DATA_W-1:0] r_pwdata,    w_pwdata;
   logic              r_hreadyout, w_hreadyout;
   logic [DATA_W-1:0] r_hrdata,    w_hrdata;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (bus.valid) begin
               w_next_state = bus.hwrite ? ST_WWAIT : ST_READ;
            end
         end
         ST_WWAIT:  w_next_state = bus.valid ? ST_WRITEP : ST_WRITE;
         ST_READ:   w_next_state = ST_RENABLE;
         ST_WRITE:  w_next_state = bus.valid ? ST_WENABLEP : ST_WENABLE;
         ST_WRITEP: w_next_state = ST_WENABLEP;
         ST_RENABLE, ST_WENABLE: begin
            if (bus.valid) begin
               w_next_state = bus.hwrite ? ST_WWAIT : ST_READ;
            end
         end
         // hwrite_reg describes the beat already pipelined behind this write.
         ST_WENABLEP: begin
            if (!bus.hwrite_reg) begin
               w_next_state = ST_READ;
            end else begin
               w_next_state = bus.valid ? ST_WRITEP : ST_WRITE;
            end
         end
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_paddr     = r_paddr;
      w_pwdata    = r_pwdata;
      w_pwrite    = r_pwrite;
      w_pselx     = r_pselx;
      w_penable   = is_enable(w_next_state);
      w_hreadyout = !is_setup(w_next_state);
      w_hrdata    = (r_state == ST_RENABLE) ? bus.prdata : r_hrdata;
      case (w_next_state)
         ST_READ: begin
            w_paddr  = bus.haddr;
            w_pwrite = 1'b0;
            w_pselx  = bus.tempselx;
         end
         // Coming out of a pipelined enable the address is one beat older.
         ST_WRITE, ST_WRITEP: begin
            w_paddr  = (r_state == ST_WENABLEP) ? bus.haddr_2 : bus.haddr_1;
            w_pwdata = bus.hwdata;
            w_pwrite = 1'b1;
            w_pselx  = bus.tempselx;
         end
         ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
            w_pselx  = r_pselx;
         end
         default: begin
            w_pselx  = '0;
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_pwrite    <= 1'b0;
         r_penable   <= 1'b0;
         r_pselx     <= '0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_hreadyout <= 1'b1;
         r_hrdata    <= '0;
      end else begin
         r_pwrite    <= w_pwrite;
         r_penable   <= w_penable;
         r_pselx     <= w_pselx;
         r_paddr     <= w_paddr;
         r_pwdata    <= w_pwdata;
         r_hreadyout <= w_hreadyout;
         r_hrdata    <= w_hrdata;
      end
   end

   assign bus.pwrite    = r_pwrite;
   assign bus.penable   = r_penable;
   assign bus.pselx     = r_pselx;
   assign bus.paddr     = r_paddr;
   assign bus.pwdata    = r_pwdata;
   assign bus.hreadyout = r_hreadyout;
   assign bus.hrdata    = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_bridge_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_bridge_fsm : directed vector bench for apb_bridge_fsm        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_apb_bridge_fsm;
   import bridge_pkg::*;

   localparam logic [31:0] RA   = 32'h8000_0010;
   localparam logic [31:0] RB   = 32'h8000_0020;
   localparam logic [31:0] WA   = 32'h8400_0004;
   localparam logic [31:0] WD   = 32'hDEAD_BEEF;
   localparam logic [31:0] A1   = 32'h8400_0100;
   localparam logic [31:0] A2   = 32'h8400_0200;
   localparam logic [31:0] A3   = 32'h8400_0300;
   localparam logic [31:0] A4   = 32'h8400_0400;
   localparam logic [31:0] A5   = 32'h8400_0500;
   localparam logic [31:0] D1   = 32'h1111_1111;
   localparam logic [31:0] D2   = 32'h2222_2222;
   localparam logic [31:0] D3   = 32'h3333_3333;
   localparam logic [31:0] D4   = 32'h4444_4444;
   localparam logic [31:0] D5   = 32'h5555_5555;
   localparam logic [31:0] JK1  = 32'hBAD0_0001;
   localparam logic [31:0] JK2  = 32'hBAD0_0002;
   localparam int          NVEC = 23;

   typedef struct {
      logic        valid, hwrite, hwrite_reg;
      logic [31:0] haddr, haddr_1, haddr_2, hwdata;
      logic [2:0]  tsel;
      logic [31:0] prdata;
      state_t      st;
      logic        pwrite, penable;
      logic [2:0]  pselx;
      logic [31:0] paddr, pwdata;
      logic        hready;
      logic [31:0] hrdata;
   } vec_t;

   logic hclk;
   logic hresetn;
   int   n_pass;
   int   n_total;
   vec_t vecs [NVEC];

   apb_bridge_fsm_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) bus ();

   apb_bridge_fsm #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   function automatic vec_t mk(
      input logic v, hw, hwr, input logic [31:0] ha, ha1, ha2, hwd,
      input logic [2:0] ts, input logic [31:0] prd,
      input state_t st, input logic pw, pe, input logic [2:0] ps,
      input logic [31:0] pa, pwd, input logic hr, input logic [31:0] hrd);
      vec_t r;
      r.valid = v;   r.hwrite = hw;   r.hwrite_reg = hwr;
      r.haddr = ha;  r.haddr_1 = ha1; r.haddr_2 = ha2; r.hwdata = hwd;
      r.tsel = ts;   r.prdata = prd;  r.st = st;
      r.pwrite = pw; r.penable = pe;  r.pselx = ps;
      r.paddr = pa;  r.pwdata = pwd;  r.hready = hr; r.hrdata = hrd;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s step%0d: got %h expected %h", name, idx, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input vec_t v);
      bus.valid      = v.valid;
      bus.hwrite     = v.hwrite;
      bus.hwrite_reg = v.hwrite_reg;
      bus.haddr      = v.haddr;
      bus.haddr_1    = v.haddr_1;
      bus.haddr_2    = v.haddr_2;
      bus.hwdata     = v.hwdata;
      bus.tempselx   = v.tsel;
      bus.prdata     = v.prdata;
   endtask

   task automatic check_all(input int idx, input vec_t v);
      chk("state",     idx, 32'(dut.r_state), 32'(v.st));
      chk("pwrite",    idx, 32'(bus.pwrite),    32'(v.pwrite));
      chk("penable",   idx, 32'(bus.penable),   32'(v.penable));
      chk("pselx",     idx, 32'(bus.pselx),     32'(v.pselx));
      chk("paddr",     idx, bus.paddr,          v.paddr);
      chk("pwdata",    idx, bus.pwdata,         v.pwdata);
      chk("hreadyout", idx, 32'(bus.hreadyout), 32'(v.hready));
      chk("hrdata",    idx, bus.hrdata,         v.hrdata);
   endtask

   initial begin
      vec_t rst_v;
      n_pass  = 0;
      n_total = 0;

      //              v  hw hwr haddr haddr_1 haddr_2 hwdata tsel    prdata  | state        pw pe pselx   paddr pwdata hr hrdata
      vecs[0]  = mk(0, 0, 0, 0,    0,   0,   0,  3'b000, 0,     ST_IDLE,     0, 0, 3'b000, 0,  0,  1, 0);
      vecs[1]  = mk(1, 0, 0, RA,   JK1, JK1, 0,  3'b001, 0,     ST_READ,     0, 0, 3'b001, RA, 0,  0, 0);
      vecs[2]  = mk(0, 0, 0, RA,   RA,  JK1, 0,  3'b001, 'h5A,  ST_RENABLE,  0, 1, 3'b001, RA, 0,  1, 0);
      vecs[3]  = mk(0, 0, 0, RA,   RA,  RA,  0,  3'b001, 'h5A,  ST_IDLE,     0, 0, 3'b000, RA, 0,  1, 'h5A);
      vecs[4]  = mk(1, 1, 0, WA,   RA,  RA,  0,  3'b010, 0,     ST_WWAIT,    0, 0, 3'b000, RA, 0,  1, 'h5A);
      vecs[5]  = mk(0, 0, 1, JK2,  WA,  JK1, WD, 3'b010, 0,     ST_WRITE,    1, 0, 3'b010, WA, WD, 0, 'h5A);
      vecs[6]  = mk(0, 0, 0, JK2,  JK2, WA,  WD, 3'b010, 0,     ST_WENABLE,  1, 1, 3'b010, WA, WD, 1, 'h5A);
      vecs[7]  = mk(0, 0, 0, 0,    0,   0,   0,  3'b000, 0,     ST_IDLE,     1, 0, 3'b000, WA, WD, 1, 'h5A);
      vecs[8]  = mk(1, 1, 0, A1,   JK1, JK1, 0,  3'b100, 0,     ST_WWAIT,    1, 0, 3'b000, WA, WD, 1, 'h5A);
      vecs[9]  = mk(1, 1, 1, A2,   A1,  JK1, D1, 3'b100, 0,     ST_WRITEP,   1, 0, 3'b100, A1, D1, 0, 'h5A);
      vecs[10] = mk(1, 1, 1, A2,   A2,  A1,  D2, 3'b100, 0,     ST_WENABLEP, 1, 1, 3'b100, A1, D1, 1, 'h5A);
      vecs[11] = mk(1, 1, 1, A3,   JK1, A2,  D2, 3'b100, 0,     ST_WRITEP,   1, 0, 3'b100, A2, D2, 0, 'h5A);
      vecs[12] = mk(1, 1, 1, A3,   A3,  JK1, D3, 3'b100, 0,     ST_WENABLEP, 1, 1, 3'b100, A2, D2, 1, 'h5A);
      vecs[13] = mk(0, 0, 1, JK2,  JK1, A3,  D3, 3'b100, 0,     ST_WRITE,    1, 0, 3'b100, A3, D3, 0, 'h5A);
      vecs[14] = mk(0, 0, 0, 0,    0,   0,   D3, 3'b100, 0,     ST_WENABLE,  1, 1, 3'b100, A3, D3, 1, 'h5A);
      vecs[15] = mk(0, 0, 0, 0,    0,   0,   0,  3'b000, 0,     ST_IDLE,     1, 0, 3'b000, A3, D3, 1, 'h5A);
      vecs[16] = mk(1, 1, 0, A4,   JK1, JK1, 0,  3'b010, 0,     ST_WWAIT,    1, 0, 3'b000, A3, D3, 1, 'h5A);
      vecs[17] = mk(1, 0, 1, RB,   A4,  JK1, D4, 3'b010, 0,     ST_WRITEP,   1, 0, 3'b010, A4, D4, 0, 'h5A);
      vecs[18] = mk(1, 0, 0, RB,   RB,  A4,  0,  3'b001, 0,     ST_WENABLEP, 1, 1, 3'b010, A4, D4, 1, 'h5A);
      vecs[19] = mk(1, 0, 0, RB,   JK1, JK2, 0,  3'b001, 0,     ST_READ,     0, 0, 3'b001, RB, D4, 0, 'h5A);
      vecs[20] = mk(0, 0, 0, RB,   RB,  RB,  0,  3'b001, 'h77,  ST_RENABLE,  0, 1, 3'b001, RB, D4, 1, 'h5A);
      vecs[21] = mk(1, 1, 0, A5,   RB,  RB,  0,  3'b010, 'h77,  ST_WWAIT,    0, 0, 3'b000, RB, D4, 1, 'h77);
      vecs[22] = mk(0, 0, 1, JK2,  A5,  JK1, D5, 3'b010, 0,     ST_WRITE,    1, 0, 3'b010, A5, D5, 0, 'h77);

      rst_v = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, ST_IDLE, 0, 0, 3'b000, 0, 0, 1, 0);

      // Reset held with a valid write request present on the AHB side.
      hresetn = 1'b0;
      drive(mk(1, 1, 1, WA, WA, WA, WD, 3'b111, 'h99, ST_IDLE, 0, 0, 0, 0, 0, 0, 0));
      @(negedge hclk);
      @(negedge hclk);
      check_all(100, rst_v);
      hresetn = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i]);
         @(negedge hclk);
         check_all(i, vecs[i]);
      end

      // Asynchronous reset in the middle of the WRITE setup cycle.
      drive(rst_v);
      #2;
      hresetn = 1'b0;
      #1;
      check_all(200, rst_v);
      @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
      chk("post_rst_state",   201, 32'(dut.r_state),   32'(ST_IDLE));
      chk("post_rst_penable", 201, 32'(bus.penable),   32'd0);
      chk("post_rst_hready",  201, 32'(bus.hreadyout), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
